// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI slave endpoint, all four CPOL/CPHA modes, MSB-first byte exchange
//
// Samples the pad-side ncs/sck/mosi in the clk domain and exchanges bytes
// with local tx/rx buffers through a req/vld byte handshake.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   cpol, cpha          SPI mode, latched at frame start
//   ncs, sck, mosi      pad inputs, asynchronous to clk
//   miso, miso_oe       pad output and its enable (1 while a frame is active)
//   tx_buf_vld/byte     next tx byte offered by the tx buffer
//   tx_buf_req          1-cycle pulse: tx byte consumed
//   rx_buf_vld          rx buffer has room for one byte
//   rx_buf_byte/req     received byte and its 1-cycle write pulse
//   status_clr          clears the sticky status bits
//   spi_status          {0, bit_cnt[2:0], abort, rx overrun, tx underrun, busy}

module spi_slave #(
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       ncs,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic       tx_buf_vld,
  input  logic [7:0] tx_buf_byte,
  output logic       tx_buf_req,
  input  logic       rx_buf_vld,
  output logic [7:0] rx_buf_byte,
  output logic       rx_buf_req,
  input  logic       status_clr,
  output logic [7:0] spi_status
);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_next;

  // Synchronizers. ncs resets low so that a frame already in progress when
  // reset is released produces no fall and is ignored until ncs cycles.
  logic [2:0] ncs_sync;
  logic [2:0] sck_sync;
  logic [1:0] mosi_sync;

  logic       cpol_l, cpha_l;
  logic [7:0] tx_sr;
  logic [7:0] rx_sr;
  logic [2:0] bit_cnt;
  logic       tx_unf, rx_ovf, frame_abort;

  logic ncs_fall, ncs_rise, sck_rise, sck_fall;
  logic lead_edge, trail_edge, sample_edge, shift_edge;

  assign ncs_fall = ~ncs_sync[1] &  ncs_sync[2];
  assign ncs_rise =  ncs_sync[1] & ~ncs_sync[2];
  assign sck_rise =  sck_sync[1] & ~sck_sync[2];
  assign sck_fall = ~sck_sync[1] &  sck_sync[2];

  // Leading edge moves away from the idle (cpol) level.
  assign lead_edge   = cpol_l ? sck_fall : sck_rise;
  assign trail_edge  = cpol_l ? sck_rise : sck_fall;
  assign sample_edge = cpha_l ? trail_edge : lead_edge;
  assign shift_edge  = cpha_l ? lead_edge  : trail_edge;

  logic       go_active, end_frame, edges_on;
  logic       sample_act, shift_act, byte_done, do_load, load_cpha;
  logic [7:0] load_byte, rx_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    go_active  = 1'b0;
    end_frame  = 1'b0;
    edges_on   = 1'b0;
    case (state)
      IDLE: begin
        if (ncs_fall) begin
          go_active  = 1'b1;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (ncs_rise) begin
          end_frame  = 1'b1;
          state_next = IDLE;
        end else begin
          edges_on = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sample_act = edges_on & sample_edge;
    byte_done  = sample_act & (bit_cnt == 3'd7);
    // In cpha=0 the load on the 8th sample already put bit7 on miso, so the
    // trailing edge that follows it (bit_cnt back at 0) must not advance.
    shift_act  = edges_on & shift_edge & (cpha_l | (bit_cnt != 3'd0));
    do_load    = go_active | byte_done;
    load_cpha  = go_active ? cpha : cpha_l;
    load_byte  = tx_buf_vld ? tx_buf_byte : IDLE_BYTE;
    rx_next    = {rx_sr[6:0], mosi_sync[1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ncs_sync    <= 3'b000;
      sck_sync    <= 3'b000;
      mosi_sync   <= 2'b00;
      cpol_l      <= 1'b0;
      cpha_l      <= 1'b0;
      tx_sr       <= 8'h00;
      rx_sr       <= 8'h00;
      bit_cnt     <= 3'd0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      tx_buf_req  <= 1'b0;
      rx_buf_req  <= 1'b0;
      rx_buf_byte <= 8'h00;
      tx_unf      <= 1'b0;
      rx_ovf      <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      ncs_sync   <= {ncs_sync[1:0], ncs};
      sck_sync   <= {sck_sync[1:0], sck};
      mosi_sync  <= {mosi_sync[0], mosi};
      tx_buf_req <= 1'b0;
      rx_buf_req <= 1'b0;

      if (go_active) begin
        cpol_l  <= cpol;
        cpha_l  <= cpha;
        miso_oe <= 1'b1;
        bit_cnt <= 3'd0;
      end

      if (end_frame) begin
        miso_oe <= 1'b0;
        bit_cnt <= 3'd0;
      end

      // cpha=0 presents bit7 at once; cpha=1 waits for the next leading edge.
      if (do_load) begin
        tx_buf_req <= tx_buf_vld;
        if (!load_cpha) begin
          miso  <= load_byte[7];
          tx_sr <= {load_byte[6:0], 1'b0};
        end else begin
          tx_sr <= load_byte;
        end
      end else if (shift_act) begin
        miso  <= tx_sr[7];
        tx_sr <= {tx_sr[6:0], 1'b0};
      end

      if (sample_act) begin
        rx_sr   <= rx_next;
        bit_cnt <= bit_cnt + 3'd1;
        if (byte_done && rx_buf_vld) begin
          rx_buf_byte <= rx_next;
          rx_buf_req  <= 1'b1;
        end
      end

      // Sticky bits: a set event outranks a simultaneous clear.
      tx_unf      <= (do_load & ~tx_buf_vld) | (tx_unf & ~status_clr);
      rx_ovf      <= (byte_done & ~rx_buf_vld) | (rx_ovf & ~status_clr);
      frame_abort <= (end_frame & (bit_cnt != 3'd0)) | (frame_abort & ~status_clr);
    end
  end

  assign spi_status = {1'b0, bit_cnt, frame_abort, rx_ovf, tx_unf, (state == ACTIVE)};

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - scoreboard testbench for spi_slave

module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpol, cpha, ncs, sck, mosi;
  logic       miso, miso_oe;
  logic       tx_buf_vld;
  logic [7:0] tx_buf_byte;
  logic       tx_buf_req;
  logic       rx_buf_vld;
  logic [7:0] rx_buf_byte;
  logic       rx_buf_req;
  logic       status_clr;
  logic [7:0] spi_status;

  int total = 0;
  int bad   = 0;
  int tx_pulses = 0;
  logic rx_req_prev = 1'b0;
  logic tx_req_prev = 1'b0;

  logic [7:0] exp_rx[$];
  logic [7:0] txq[$];

  always #5 clk = ~clk;

  spi_slave dut (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha),
    .ncs(ncs), .sck(sck), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .tx_buf_vld(tx_buf_vld), .tx_buf_byte(tx_buf_byte), .tx_buf_req(tx_buf_req),
    .rx_buf_vld(rx_buf_vld), .rx_buf_byte(rx_buf_byte), .rx_buf_req(rx_buf_req),
    .status_clr(status_clr), .spi_status(spi_status)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Tx buffer model: offers the head of txq, pops when the DUT consumes it.
  always @(negedge clk) begin
    if (tx_buf_req && txq.size() > 0) void'(txq.pop_front());
    tx_buf_vld  = (txq.size() > 0);
    tx_buf_byte = (txq.size() > 0) ? txq[0] : 8'h00;
  end

  // Monitor: pops expected rx bytes whenever the DUT writes one.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_buf_req) begin
        if (exp_rx.size() == 0) begin
          check("rx_unexpected_req", {8'h00, rx_buf_byte}, 16'hFFFF);
        end else begin
          check("rx_byte", {8'h00, rx_buf_byte}, {8'h00, exp_rx.pop_front()});
        end
        if (rx_req_prev) check("rx_req_width", 16'd2, 16'd1);
      end
      if (tx_buf_req) begin
        tx_pulses++;
        if (tx_req_prev) check("tx_req_width", 16'd2, 16'd1);
      end
    end
    rx_req_prev = rx_buf_req;
    tx_req_prev = tx_buf_req;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_status();
    status_clr = 1'b1;
    wait_clk(1);
    status_clr = 1'b0;
    wait_clk(1);
  endtask

  // SPI master: shifts mo[15:16-nbits] out MSB-first and captures miso at
  // each sample edge into got.
  task automatic xfer(input logic pol, input logic pha, input logic [15:0] mo,
                      input int nbits, output logic [15:0] got);
    got  = '0;
    cpol = pol;
    cpha = pha;
    sck  = pol;
    wait_clk(4);
    ncs = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nbits; i++) begin
      if (!pha) begin
        mosi = mo[15-i];
        wait_clk(6);
        got[15-i] = miso;
        sck = ~pol;
        wait_clk(6);
        sck = pol;
      end else begin
        sck  = ~pol;
        mosi = mo[15-i];
        wait_clk(6);
        got[15-i] = miso;
        sck = pol;
        wait_clk(6);
      end
    end
    wait_clk(6);
    ncs = 1'b1;
    wait_clk(8);
  endtask

  logic [15:0] got;

  initial begin
    rst = 1'b1; cpol = 1'b0; cpha = 1'b0; ncs = 1'b1; sck = 1'b0; mosi = 1'b0;
    rx_buf_vld = 1'b1; status_clr = 1'b0;
    tx_buf_vld = 1'b0; tx_buf_byte = 8'h00;
    wait_clk(3);
    check("reset_outputs", {12'h000, miso, miso_oe, tx_buf_req, rx_buf_req}, 16'h0000);
    check("reset_rx_byte", {8'h00, rx_buf_byte}, 16'h0000);
    check("reset_status", {8'h00, spi_status}, 16'h0000);
    rst = 1'b0;
    wait_clk(4);

    // Mode 0: tx 55 plus a prefetch byte, master sends A3.
    txq.push_back(8'h55); txq.push_back(8'h00);
    exp_rx.push_back(8'hA3);
    tx_pulses = 0;
    xfer(1'b0, 1'b0, 16'hA300, 8, got);
    check("m0_miso", {8'h00, got[15:8]}, 16'h0055);
    check("m0_tx_pulses", 16'(tx_pulses), 16'd2);
    check("m0_status", {13'h0, spi_status[3:1]}, 16'h0000);
    check("m0_idle", {14'h0, miso_oe, spi_status[0]}, 16'h0000);

    // Mode 3: two bytes each way.
    txq.push_back(8'hA5); txq.push_back(8'h3C); txq.push_back(8'h11);
    exp_rx.push_back(8'h0F); exp_rx.push_back(8'hF0);
    tx_pulses = 0;
    xfer(1'b1, 1'b1, 16'h0FF0, 16, got);
    check("m3_miso", got, 16'hA53C);
    check("m3_tx_pulses", 16'(tx_pulses), 16'd3);
    check("m3_bitcnt", {13'h0, spi_status[6:4]}, 16'h0000);
    check("m3_status", {13'h0, spi_status[3:1]}, 16'h0000);

    // Mode 1 with no tx byte: underrun shifts IDLE_BYTE.
    exp_rx.push_back(8'h96);
    tx_pulses = 0;
    xfer(1'b0, 1'b1, 16'h9600, 8, got);
    check("m1_miso", {8'h00, got[15:8]}, 16'h00FF);
    check("m1_underrun", {15'h0, spi_status[1]}, 16'h0001);
    check("m1_tx_pulses", 16'(tx_pulses), 16'd0);
    clr_status();
    check("m1_clr", {15'h0, spi_status[1]}, 16'h0000);

    // Mode 2 with rx buffer full: byte dropped, overrun flagged.
    rx_buf_vld = 1'b0;
    txq.push_back(8'hC3); txq.push_back(8'h00);
    xfer(1'b1, 1'b0, 16'h3E00, 8, got);
    check("m2_miso", {8'h00, got[15:8]}, 16'h00C3);
    check("m2_rx_hold", {8'h00, rx_buf_byte}, 16'h0096);
    check("m2_overrun", {15'h0, spi_status[2]}, 16'h0001);
    rx_buf_vld = 1'b1;
    clr_status();
    check("m2_clr", {8'h00, spi_status}, 16'h0000);

    // Abort after 5 sample edges.
    txq.push_back(8'h77);
    tx_pulses = 0;
    xfer(1'b0, 1'b0, 16'hB000, 5, got);
    check("ab_miso", {11'h0, got[15:11]}, {11'h0, 5'b01110});
    check("ab_flag", {15'h0, spi_status[3]}, 16'h0001);
    check("ab_bitcnt", {13'h0, spi_status[6:4]}, 16'h0000);
    check("ab_idle", {14'h0, miso_oe, spi_status[0]}, 16'h0000);
    check("ab_tx_pulses", 16'(tx_pulses), 16'd1);
    clr_status();

    // Reset pulsed mid-byte; the rest of that frame must be ignored.
    txq.push_back(8'h3F);
    fork
      xfer(1'b0, 1'b0, 16'hFF00, 8, got);
      begin
        wait_clk(40);
        rst = 1'b1;
        #2;
        check("rst_outputs", {12'h000, miso, miso_oe, tx_buf_req, rx_buf_req}, 16'h0000);
        check("rst_status", {8'h00, spi_status}, 16'h0000);
        check("rst_rx_byte", {8'h00, rx_buf_byte}, 16'h0000);
        wait_clk(2);
        rst = 1'b0;
        wait_clk(20);
        check("rst_ignored_oe", {15'h0, miso_oe}, 16'h0000);
      end
    join
    check("rst_after_status", {8'h00, spi_status}, 16'h0000);
    check("rst_after_rx", {8'h00, rx_buf_byte}, 16'h0000);
    txq.delete();
    wait_clk(2);

    // Full mode 0 frame after reset.
    txq.push_back(8'hA6); txq.push_back(8'h00);
    exp_rx.push_back(8'h5A);
    xfer(1'b0, 1'b0, 16'h5A00, 8, got);
    check("post_rst_miso", {8'h00, got[15:8]}, 16'h00A6);
    check("post_rst_rx", {8'h00, rx_buf_byte}, 16'h005A);
    check("post_rst_status", {13'h0, spi_status[3:1]}, 16'h0000);

    wait_clk(4);
    check("exp_rx_drained", 16'(exp_rx.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI slave endpoint, the responder counterpart of `spi_master`: samples external `ncs`/`sck`/`mosi` in the system `clk` domain, shifts bytes MSB-first in all four CPOL/CPHA modes, and exchanges bytes with local buffers through the same req/vld byte handshake `spi_master` uses. It sits between the chip pads and the local tx/rx byte buffers.

## Interface
- `IDLE_BYTE`, 8'hFF, byte shifted out on `miso` when no tx byte is available (underrun).
- `clk` in 1 — system clock; the only clock in the block.
- `rst` in 1 — asynchronous reset, active-high.
- `cpol` in 1 — SCK idle level; sampled on frame start.
- `cpha` in 1 — 0: sample on the leading edge; 1: sample on the trailing edge. Sampled on frame start.
- `ncs` in 1 — chip select from the pad, active-low, asynchronous to `clk`.
- `sck` in 1 — serial clock from the pad, asynchronous to `clk`.
- `mosi` in 1 — serial data in, asynchronous to `clk`.
- `miso` out 1 — serial data out.
- `miso_oe` out 1 — pad output enable; 1 while a frame is active.
- `tx_buf_vld` in 1 — a tx byte is available on `tx_buf_byte`.
- `tx_buf_byte` in 8 — next byte to transmit.
- `tx_buf_req` out 1 — 1-cycle pulse: `tx_buf_byte` consumed this cycle.
- `rx_buf_vld` in 1 — the rx buffer has room for one byte.
- `rx_buf_byte` out 8 — last received byte; held until the next byte completes.
- `rx_buf_req` out 1 — 1-cycle pulse: `rx_buf_byte` is valid, write it.
- `status_clr` in 1 — 1-cycle pulse; clears the sticky status bits.
- `spi_status` out 8 — [0] busy, [1] tx underrun, [2] rx overrun, [3] frame abort, [6:4] bit count, [7] 0.

## Operation
- Input synchronization:
  - `ncs`, `sck` and `mosi` each pass through 2 flops, plus a third flop for edge detection.
  - Edges are decoded from the sync2/sync3 pair.
  - `mosi` is taken from sync2 on the cycle a sample edge is detected.
- Edge naming: the leading edge is the transition away from the `cpol` level; the trailing edge returns to it.
- Sample edge: leading edge when `cpha`=0, trailing edge when `cpha`=1.
- Shift (drive) edge: the opposite edge.
- FSM IDLE:
  - `miso_oe`=0 and the bit counter is 0.
  - On a synchronized `ncs` fall: latch `cpol`/`cpha`, perform a tx load, go to ACTIVE.
- FSM ACTIVE:
  - Process edges.
  - On a synchronized `ncs` rise go to IDLE. If the bit count is not 0, discard the partial rx byte and set status[3].
  - No `rx_buf_req` is generated for a partial byte.
- Tx load:
  - If `tx_buf_vld`=1: shift register ← `tx_buf_byte` and pulse `tx_buf_req`.
  - Otherwise: shift register ← `IDLE_BYTE` and set status[1].
- Tx loads occur on frame start and on the 8th sample edge of each byte. This is an eager prefetch: a byte loaded after the last full byte is consumed even if `ncs` then rises.
- `miso` driving:
  - `cpha`=0: `miso` = shift register bit7 immediately after each load; each shift edge advances one bit.
  - `cpha`=1: each shift edge (leading edge) outputs the next bit, starting with bit7 on the first leading edge after a load.
- Rx:
  - Each sample edge shifts `mosi` into the rx shift register and increments the 3-bit counter, which wraps 7→0.
  - On the 8th sample, if `rx_buf_vld`=1: `rx_buf_byte` ← byte and pulse `rx_buf_req`.
  - Otherwise the byte is dropped, status[2] is set, and `rx_buf_byte` is unchanged.
- Status:
  - [0] = (state == ACTIVE); [6:4] = bit counter.
  - Sticky bits clear on `status_clr`. A set event in the same cycle wins over the clear.
- `cpol`/`cpha` changes during ACTIVE are ignored until the next frame.

## Timing
- Reset values: `miso`=0, `miso_oe`=0, `tx_buf_req`=0, `rx_buf_req`=0, `rx_buf_byte`=8'h00, `spi_status`=8'h00, FSM=IDLE.
- `rst` mid-frame aborts immediately. After release the block waits in IDLE for the next `ncs` fall; a frame in progress at release is ignored until `ncs` rises and falls again.
- Pad edge to internal edge pulse: 3 `clk` edges.
- `miso`, `miso_oe`, `tx_buf_req` and `rx_buf_req` are registered and update on the clk edge after the pulse, i.e. 3–4 `clk` cycles after the pad edge.
- Constraints on the external master:
  - `sck` high and low phases ≥ 4 `clk` periods.
  - `ncs` fall to first `sck` edge ≥ 6 `clk` periods.
  - Last `sck` edge to `ncs` rise ≥ 4 `clk` periods.
- `tx_buf_req` and `rx_buf_req` are never high for more than 1 cycle.
- `tx_buf_byte` must be stable in the load cycle. `tx_buf_vld`/`rx_buf_vld` are sampled only in load/complete cycles.

## Test plan
- Mode 0 (cpol=0,cpha=0), `tx_buf_byte`=8'h55 valid, master sends 8'hA3 → `miso` bits 0,1,0,1,0,1,0,1; `rx_buf_byte`=8'hA3 with one `rx_buf_req` pulse; `tx_buf_req` pulses at frame start and at byte end; status[3:1]=0.
- Mode 3 (cpol=1,cpha=1), two bytes 8'hA5,8'h3C queued, master sends 8'h0F,8'hF0 → `miso` carries A5 then 3C; rx pulses give 0F then F0; status[6:4]=0 after the frame.
- Mode 1 with `tx_buf_vld`=0 → `miso` shifts 8'hFF and status[1]=1; `status_clr` → status[1]=0.
- Mode 2 with `rx_buf_vld`=0 → no `rx_buf_req`, `rx_buf_byte` keeps its prior value, status[2]=1.
- `ncs` rises after 5 sample edges → FSM returns to IDLE, no `rx_buf_req`, status[3]=1, bit count 0, `miso_oe`=0.
- `rst` pulsed mid-byte → all outputs at reset values within 1 cycle; the next full frame in mode 0 with 8'h5A transfers correctly.
